crc8_framer: RTL and testbench

CRC8_FRAMER -- requirements
Module: crc8_framer

---
 rtl/crc8_framer.sv | 130 +++++++++++++
 tb/tb_crc8_framer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_framer.sv
// Frame builder: forwards payload bytes and appends a CRC-8 trailer byte.
// Contains the crc8 engine plus the crc8_framer top.

module crc8 #(
    parameter logic [7:0] POLYNOMIAL = 8'h07
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       vld_p0,
    output logic [7:0] crc_o
);

    // MSB-first, zero-initialised, unreflected CRC-8 over one byte.
    function automatic logic [7:0] crc_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_o <= 8'h00;
        end else if (vld_p0) begin
            crc_o <= crc_next(crc_o, data_i);
        end
    end

endmodule

module crc8_framer #(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter int         LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic [LEN_W-1:0] frame_len_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC_WAIT,
        APPEND
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [7:0]       eng_crc;
    logic             out_free;
    logic             in_xfer;
    logic             crc_load;
    logic             eng_rst;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    assign out_free  = !m_valid_o || m_ready_i;
    assign s_ready_o = rst_ni && ((state_q == IDLE) || (state_q == PAYLOAD)) && out_free;
    assign in_xfer   = s_valid_i && s_ready_o;
    assign crc_load  = (state_q == APPEND) && out_free;
    assign busy_o    = (state_q != IDLE);

    // Engine is cleared as the CRC leaves it, so the next frame starts from zero.
    assign eng_rst   = !rst_ni || crc_load;

    crc8 #(
        .POLYNOMIAL(POLYNOMIAL)
    ) u_crc8 (
        .clk_i (clk_i),
        .rst_i (eng_rst),
        .data_i(s_data_i),
        .vld_p0(in_xfer),
        .crc_o (eng_crc)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            m_data_o    <= 8'h00;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            frame_len_o <= '0;
            byte_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer) state_q <= s_last_i ? CRC_WAIT : PAYLOAD;
                end
                PAYLOAD: begin
                    if (in_xfer && s_last_i) state_q <= CRC_WAIT;
                end
                CRC_WAIT: state_q <= APPEND;
                APPEND: begin
                    if (out_free) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (in_xfer) begin
                m_data_o   <= s_data_i;
                m_valid_o  <= 1'b1;
                m_last_o   <= 1'b0;
                byte_cnt_q <= (state_q == IDLE) ? LEN_W'(1) : sat_inc(byte_cnt_q);
            end else if (crc_load) begin
                m_data_o    <= eng_crc;
                m_valid_o   <= 1'b1;
                m_last_o    <= 1'b1;
                frame_len_o <= byte_cnt_q;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc8_framer.sv
// Bench for crc8_framer: random and directed frames against a long-division CRC model.
module tb_crc8_framer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;
    logic [15:0] frame_len_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    crc8_framer #(
        .POLYNOMIAL(8'h07),
        .LEN_W     (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_last_i   (s_last_i),
        .s_ready_o  (s_ready_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_last_o   (m_last_o),
        .m_ready_i  (m_ready_i),
        .frame_len_o(frame_len_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    int         len_q[$];
    logic [7:0] frame[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         rand_rdy = 1'b0;
    bit         mon_en   = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Remainder of (message * x^8) divided by x^8 + POLYNOMIAL, bit by bit.
    function automatic logic [7:0] ref_crc();
        logic [8:0] r;
        logic [7:0] cur;
        int         nbits;
        logic       b;
        r = 9'h000;
        nbits = frame.size() * 8 + 8;
        for (int i = 0; i < nbits; i++) begin
            if (i < frame.size() * 8) begin
                cur = frame[i / 8];
                b = cur[7 - (i % 8)];
            end else begin
                b = 1'b0;
            end
            r = {r[7:0], b};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            m_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_valid_o, 1);
                    check("stall_data", m_data_o, prev_d);
                    check("stall_last", m_last_o, prev_l);
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_d = m_data_o;
                prev_l = m_last_o;
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_data_o, e.d);
                        check("out_last", m_last_o, e.l);
                        if (e.l) check("frame_len", frame_len_o, len_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int waits;
        waits = 0;
        s_data_i  = d;
        s_valid_i = 1'b1;
        s_last_i  = l;
        @(negedge clk_i);
        while (!s_ready_o) begin
            waits++;
            if (waits > 200) begin
                check("sready_timeout", waits, 0);
                s_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // With tail set (sink always ready), also checks the two-cycle CRC gap
    // and that a byte offered during it is refused.
    task automatic send_frame(input bit tail);
        exp_t e;
        foreach (frame[i]) begin
            e.d = frame[i];
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        e.d = ref_crc();
        e.l = 1'b1;
        exp_q.push_back(e);
        len_q.push_back(frame.size());
        foreach (frame[i]) send_byte(frame[i], (i == frame.size() - 1));
        if (tail) begin
            s_data_i  = 8'hAA;
            s_valid_i = 1'b1;
            s_last_i  = 1'b0;
            @(negedge clk_i);
            check("sready_crc_wait", s_ready_o, 0);
            check("busy_crc_wait", busy_o, 1);
            @(negedge clk_i);
            check("sready_append", s_ready_o, 0);
            @(posedge clk_i);
            #1;
            s_valid_i = 1'b0;
            @(negedge clk_i);
            check("sready_idle", s_ready_o, 1);
            check("busy_idle", busy_o, 0);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic load_check_string();
        frame.delete();
        for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk_i);
            cyc++;
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni    = 1'b0;
        s_data_i  = 8'h00;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_m_valid", m_valid_o, 0);
        check("rst_m_last", m_last_o, 0);
        check("rst_m_data", m_data_o, 0);
        check("rst_frame_len", frame_len_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_s_ready", s_ready_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("release_s_ready", s_ready_o, 1);
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;

        load_check_string();
        send_frame(1'b1);
        frame.delete(); frame.push_back(8'h01);
        send_frame(1'b1);
        frame.delete(); frame.push_back(8'h00);
        send_frame(1'b1);

        rand_rdy = 1'b1;
        load_check_string();
        send_frame(1'b0);
        drain("drain_stalled");

        rand_rdy = 1'b0;
        frame.delete(); frame.push_back(8'h01);
        send_frame(1'b0);
        load_check_string();
        send_frame(1'b1);

        for (int f = 0; f < 6; f++) begin
            int n;
            rand_rdy = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 16);
            frame.delete();
            for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
            send_frame(1'b0);
        end
        drain("drain_random");

        rand_rdy = 1'b0;
        @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_s_ready", s_ready_o, 0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("midrst_m_valid", m_valid_o, 0);
        check("midrst_m_last", m_last_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_frame_len", frame_len_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("midrst_release_ready", s_ready_o, 1);
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        load_check_string();
        send_frame(1'b1);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
